math_multiplier_shared_ctrl: RTL and testbench
==============================================

// Module: math_multiplier_shared_ctrl
// PURPOSE
//  Shares one math_multiplier_carry_save array between M requesters. Round-robin arbitration,
//  operand capture, multi-cycle settle window for the combinational array, held result channel.
//  Sits between client pipelines and the array. Gives slow arrays a multicycle path instead of
//  one pipeline stage per client.
// PARAMETERS
//  N             8  operand width; the product is 2N bits
//  M             4  number of requesters (>=2)
//  SETTLE_CYCLES 2  cycles the array settles after operand capture (>=1)
//  ID_W          $clog2(M)  result tag width (localparam, forced >=1)
// PORTS
//  i_clk            in   1      clock
//  i_rst            in   1      reset, asynchronous, active-high
//  i_req_valid      in   M      per-requester request valid
//  i_req_a          in   M*N    packed multiplicands; requester k at [k*N+:N]
//  i_req_b          in   M*N    packed multipliers; requester k at [k*N+:N]
//  ow_req_ready     out  M      one-hot grant/accept, combinational, only in accept states
//  i_result_ready   in   1      downstream accepts result
//  o_result_valid   out  1      result held valid
//  o_result         out  2N     product a*b, unsigned
//  o_result_id      out  ID_W   index of the requester that owns o_result
//  o_busy           out  1      high in SETTLE or DONE
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, rr_ptr=0, settle counter=0, all o_* = 0, operand regs = 0.
//    A reset mid-operation aborts the operation. No result is emitted. The requester is not re-served.
//  - FSM IDLE / SETTLE / DONE:
//    IDLE: if |i_req_valid, grant g = first set bit at or above rr_ptr, wrapping mod M.
//          Assert ow_req_ready[g] in the same cycle. Capture a,b,g into regs. rr_ptr<=(g+1)%M.
//          cnt<=SETTLE_CYCLES-1. Next state SETTLE.
//    SETTLE: the array sees only the operand regs. If cnt==0: o_result<=product,
//          o_result_id<=g, o_result_valid<=1, next DONE. Otherwise cnt<=cnt-1.
//    DONE: hold o_result, o_result_id and o_result_valid stable while !i_result_ready.
//          On i_result_ready: with |i_req_valid, grant and capture as in IDLE in that same cycle,
//          then go to SETTLE with o_result_valid<=0. With no request, go to IDLE with o_result_valid<=0.
//  - Latency: handshake in cycle T -> o_result_valid high from T+SETTLE_CYCLES+1.
//    Back-to-back throughput is one result per SETTLE_CYCLES+1 cycles.
//  - ow_req_ready is 0 in SETTLE, and 0 in DONE while !i_result_ready. At most one bit is set.
//  - Requesters hold valid and operands until ready. A valid dropped before grant is never served.
//  - rr_ptr advances only on a grant. A lone requester is served repeatedly.
//    No requester waits more than M-1 grants.
//  - Arithmetic: unsigned. The product is always exact 2N bits, e.g. (2^N-1)^2 = 2^2N - 2^(N+1) + 1.
// CONFIGURATION
//  MATH_MULT_CTRL_STATS_EN defined: adds ports o_op_count (out, 32) and o_stall_count (out, 32).
//    o_op_count increments on each result handshake. o_stall_count increments each cycle that
//    o_result_valid && !i_result_ready. Both saturate at 2^32-1 and reset to 0.
//  Undefined: these ports and counters are absent. Core behaviour is identical.
// STRUCTURE
//  - Package math_mult_ctrl_pkg: typedef enum logic [1:0] {IDLE, SETTLE, DONE} mult_ctrl_state_t;
//    counter-width helper function.
//  - Sub-module math_mult_ctrl_rr_arb holds the combinational masked-priority round-robin pick
//    from (req, rr_ptr) to one-hot grant plus index. The FSM owns rr_ptr.
//  - One math_multiplier_carry_save #(N) instance, fed from the operand regs.
// TESTING (N=8, M=4, SETTLE_CYCLES=2)
//  1 req0 a=3 b=5 at T -> ow_req_ready=0001 at T; o_result=15, id=0, valid at T+3;
//    deassert after i_result_ready.
//  2 all four valid continuously, i_result_ready=1 -> grant order 0,1,2,3,0;
//    a new grant every 3 cycles in DONE.
//  3 a=255 b=255 -> 65025 (0xFE01). a=0 b=200 -> 0. a=128 b=2 -> 256.
//  4 i_result_ready=0 for 10 cycles in DONE -> result, id and valid stable; ow_req_ready=0;
//    o_busy=1; then it drains.
//  5 i_rst pulsed in SETTLE -> valid=0, busy=0, rr_ptr=0 at once; next req1 served with id=1.
//  6 STATS_EN: 5 ops with 7 stall cycles -> o_op_count=5, o_stall_count=7.

Source files
------------

// File: rtl/math_mult_ctrl_pkg.sv
// Shared state type and sizing helper for the shared multiplier controller.
package math_mult_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} mult_ctrl_state_t;

    // Width needed to hold 0..value-1, never less than one bit.
    function automatic int min1_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/math_mult_ctrl_rr_arb.sv
// Combinational round-robin pick: lowest request at or above ptr, else lowest request overall.
module math_mult_ctrl_rr_arb #(
    parameter int M    = 4,
    parameter int ID_W = 2
) (
    input  logic [M-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [M-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [M-1:0] masked;
    logic [M-1:0] cand;

    always_comb begin
        masked = '0;
        for (int i = 0; i < M; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
        cand = (|masked) ? masked : req;
        idx  = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (cand[i]) idx = ID_W'(i);
        end
        any   = |req;
        grant = '0;
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/math_multiplier_carry_save.sv
// Combinational unsigned N x N array multiplier: partial products folded through 3:2 carry-save rows.
module math_multiplier_carry_save #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] sum;
    logic [2*N-1:0] carry;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] sum_nxt;

    // Carries shifted past bit 2N-1 are always zero for an exact N x N product.
    always_comb begin
        sum     = '0;
        carry   = '0;
        pp      = '0;
        sum_nxt = '0;
        for (int i = 0; i < N; i++) begin
            pp      = b[i] ? ({{N{1'b0}}, a} << i) : '0;
            sum_nxt = sum ^ carry ^ pp;
            carry   = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
            sum     = sum_nxt;
        end
        p = sum + carry;
    end

endmodule

// File: rtl/math_multiplier_shared_ctrl.sv
// Shares one carry-save multiplier array between M round-robin requesters with a multicycle settle window.
// Optional define MATH_MULT_CTRL_STATS_EN adds saturating result-handshake and stall counters.
module math_multiplier_shared_ctrl
    import math_mult_ctrl_pkg::*;
#(
    parameter int N             = 8,
    parameter int M             = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [M-1:0]                i_req_valid,
    input  logic [M*N-1:0]              i_req_a,
    input  logic [M*N-1:0]              i_req_b,
    output logic [M-1:0]                ow_req_ready,
    input  logic                        i_result_ready,
    output logic                        o_result_valid,
    output logic [2*N-1:0]              o_result,
    output logic [min1_clog2(M)-1:0]    o_result_id,
    output logic                        o_busy
`ifdef MATH_MULT_CTRL_STATS_EN
    ,
    output logic [31:0]                 o_op_count,
    output logic [31:0]                 o_stall_count
`endif
);

    localparam int ID_W  = min1_clog2(M);
    localparam int CNT_W = min1_clog2(SETTLE_CYCLES);

    mult_ctrl_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  op_id;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [M-1:0]     pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             accept;
    logic             take;
    logic [2*N-1:0]   product;

    math_mult_ctrl_rr_arb #(.M(M), .ID_W(ID_W)) u_arb (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The array only ever sees the captured operands, so its path is multicycle.
    math_multiplier_carry_save #(.N(N)) u_array (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = !i_rst;
                if (pick_any) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                if (i_result_ready) begin
                    accept    = !i_rst;
                    state_nxt = pick_any ? SETTLE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        take         = accept && pick_any;
        ow_req_ready = accept ? pick_grant : '0;
        o_busy       = (state != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            rr_ptr         <= '0;
            op_a           <= '0;
            op_b           <= '0;
            op_id          <= '0;
            o_result       <= '0;
            o_result_id    <= '0;
            o_result_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                op_a   <= i_req_a[int'(pick_idx)*N +: N];
                op_b   <= i_req_b[int'(pick_idx)*N +: N];
                op_id  <= pick_idx;
                rr_ptr <= (int'(pick_idx) == M - 1) ? '0 : pick_idx + 1'b1;
                cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == SETTLE && cnt == '0) begin
                o_result       <= product;
                o_result_id    <= op_id;
                o_result_valid <= 1'b1;
            end else if (state == DONE && i_result_ready) begin
                o_result_valid <= 1'b0;
            end
        end
    end

`ifdef MATH_MULT_CTRL_STATS_EN
    localparam logic [31:0] CNT_MAX = '1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_op_count    <= '0;
            o_stall_count <= '0;
        end else begin
            if (o_result_valid && i_result_ready && o_op_count != CNT_MAX)
                o_op_count <= o_op_count + 1'b1;
            if (o_result_valid && !i_result_ready && o_stall_count != CNT_MAX)
                o_stall_count <= o_stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_math_multiplier_shared_ctrl.sv
// Self-checking bench for math_multiplier_shared_ctrl (N=8, M=4, SETTLE_CYCLES=2) with a transaction-level model.
`timescale 1ns/1ps
module tb_math_multiplier_shared_ctrl;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int SC = 2;

    logic            clk          = 1'b0;
    logic            rst          = 1'b1;
    logic [M-1:0]    req_valid    = '0;
    logic [M*N-1:0]  req_a        = '0;
    logic [M*N-1:0]  req_b        = '0;
    logic            result_ready = 1'b1;
    logic [M-1:0]    req_ready;
    logic            result_valid;
    logic [2*N-1:0]  result;
    logic [1:0]      result_id;
    logic            busy;
`ifdef MATH_MULT_CTRL_STATS_EN
    logic [31:0]     op_count;
    logic [31:0]     stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: an operation in flight counts down, then becomes the held result.
    bit     m_pending = 0;
    bit     m_valid   = 0;
    int     m_left    = 0;
    int     m_ptr     = 0;
    int     m_pa      = 0;
    int     m_pb      = 0;
    int     m_pid     = 0;
    int     m_id      = 0;
    longint m_res     = 0;
    int     m_ops     = 0;
    int     m_stalls  = 0;

    int grants[$];
    int gcyc[$];
    int order[5] = '{0, 1, 2, 3, 0};

    math_multiplier_shared_ctrl #(.N(N), .M(M), .SETTLE_CYCLES(SC)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .ow_req_ready   (req_ready),
        .i_result_ready (result_ready),
        .o_result_valid (result_valid),
        .o_result       (result),
        .o_result_id    (result_id),
        .o_busy         (busy)
`ifdef MATH_MULT_CTRL_STATS_EN
        ,
        .o_op_count     (op_count),
        .o_stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int rr_pick(input logic [M-1:0] req, input int ptr);
        for (int i = 0; i < M; i++) begin
            if (req[(ptr + i) % M]) return (ptr + i) % M;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model
        int           g;
        logic [M-1:0] exp_ready;
        g         = -1;
        exp_ready = '0;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_valid", result_valid, 0);
            chk("rst_result", result, 0);
            chk("rst_id", result_id, 0);
            m_pending = 0; m_valid = 0; m_left = 0; m_ptr = 0;
            m_res = 0; m_id = 0; m_ops = 0; m_stalls = 0;
        end else begin
            if (!m_pending && (!m_valid || result_ready)) g = rr_pick(req_valid, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("ready", req_ready, exp_ready);
            chk("busy", busy, m_pending || m_valid);
            chk("valid", result_valid, m_valid);
            if (m_valid) begin
                chk("result", result, m_res);
                chk("result_id", result_id, m_id);
                if (result_ready) m_ops++;
                else m_stalls++;
            end
            if (m_pending) begin
                if (m_left == 0) begin
                    m_pending = 0;
                    m_valid   = 1;
                    m_res     = longint'(m_pa) * longint'(m_pb);
                    m_id      = m_pid;
                end else begin
                    m_left--;
                end
            end else if (m_valid && result_ready) begin
                m_valid = 0;
            end
            if (g >= 0) begin
                m_pending = 1;
                m_left    = SC - 1;
                m_pa      = int'(req_a[g*N +: N]);
                m_pb      = int'(req_b[g*N +: N]);
                m_pid     = g;
                m_ptr     = (g + 1) % M;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int k, input int a, input int b);
        bit got;
        got = 0;
        tick();
        req_a[k*N +: N] = N'(a);
        req_b[k*N +: N] = N'(b);
        req_valid[k]    = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = req_ready[k];
        end
        chk("grant_seen", got, 1);
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic await_result(input string name, input int id, input longint exp);
        bit got;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = result_valid;
        end
        chk({name, "_seen"}, got, 1);
        if (got) begin
            chk(name, result, exp);
            chk({name, "_id"}, result_id, id);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        tick();
        rst = 1'b0;

        // Single request: grant in the same cycle, result three cycles later.
        req_a[0 +: N] = 8'd3;
        req_b[0 +: N] = 8'd5;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        chk("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_not_yet", result_valid, 0);
        @(negedge clk);
        chk("t1_valid", result_valid, 1);
        chk("t1_result", result, 15);
        chk("t1_id", result_id, 0);
        @(negedge clk);
        chk("t1_drained", result_valid, 0);

        // All four requesting continuously from a fresh pointer.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int k = 0; k < M; k++) begin
            req_a[k*N +: N] = N'(10 + k);
            req_b[k*N +: N] = 8'd3;
        end
        req_valid = '1;
        for (int c = 0; c < 40 && grants.size() < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                grants.push_back($clog2(req_ready));
                gcyc.push_back(c);
            end
        end
        tick();
        req_valid = '0;
        chk("t2_grant_count", grants.size(), 5);
        for (int i = 0; i < grants.size(); i++) begin
            chk("t2_order", grants[i], order[i]);
            if (i > 0) chk("t2_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        await_result("t2_last", 0, 30);

        // Arithmetic corners.
        request(2, 255, 255);
        await_result("t3_max", 2, 65025);
        request(1, 0, 200);
        await_result("t3_zero", 1, 0);
        request(3, 128, 2);
        await_result("t3_pow2", 3, 256);

        // Back-pressure in DONE with another requester waiting.
        tick();
        result_ready = 1'b0;
        request(3, 7, 9);
        req_a[1*N +: N] = 8'd6;
        req_b[1*N +: N] = 8'd7;
        req_valid[1]    = 1'b1;
        await_result("t4_res", 3, 63);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", result_valid, 1);
            chk("t4_hold_result", result, 63);
            chk("t4_hold_id", result_id, 3);
            chk("t4_no_grant", req_ready, 0);
            chk("t4_busy", busy, 1);
        end
        tick();
        result_ready = 1'b1;
        @(negedge clk);
        chk("t4_grant1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        await_result("t4_next", 1, 42);

        // Reset in SETTLE aborts the operation and clears the pointer.
        request(0, 9, 9);
        rst = 1'b1;
        #1;
        chk("t5_valid", result_valid, 0);
        chk("t5_busy", busy, 0);
        tick();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        req_a[0 +: N] = 8'd2; req_b[0 +: N] = 8'd3;
        req_a[N +: N] = 8'd4; req_b[N +: N] = 8'd5;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t5_ptr_reset", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        await_result("t5_req0", 0, 6);
        chk("t5_grant1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        await_result("t5_req1", 1, 20);

`ifdef MATH_MULT_CTRL_STATS_EN
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        result_ready = 1'b0;
        request(2, 1, 1);
        await_result("t6_first", 2, 1);
        repeat (6) @(negedge clk);
        tick();
        result_ready = 1'b1;
        request(0, 2, 2);
        await_result("t6_op2", 0, 4);
        request(1, 3, 3);
        await_result("t6_op3", 1, 9);
        request(3, 4, 4);
        await_result("t6_op4", 3, 16);
        request(2, 5, 5);
        await_result("t6_op5", 2, 25);
        repeat (2) @(negedge clk);
        chk("t6_op_count", op_count, 5);
        chk("t6_stall_count", stall_count, 7);
        chk("t6_op_model", op_count, m_ops);
        chk("t6_stall_model", stall_count, m_stalls);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
